// File: rtl/eth_status_monitor_pkg.sv
// -----------------------------------------------------------------------------
// eth_status_monitor_pkg
// Shared types and helpers for the Ethernet MAC status statistics block.
//   rd_state_t : read-port FSM states (ST_IDLE, ST_RESP)
//   RD_INDEX_W : width of the counter index on the read request port
//   sat_inc    : saturating increment for counters up to 64 bits wide
// Optional feature macro used by the block: ETH_STATUS_MONITOR_TIMESTAMP_EN
// -----------------------------------------------------------------------------
package eth_status_monitor_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } rd_state_t;

   localparam int RD_INDEX_W = 7;

   // Increment val unless it already equals the all-ones value of a
   // counter that is 'width' bits wide. The value is carried zero-extended
   // to 64 bits so one function serves every counter width.
   function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                           input int unsigned width);
      logic [63:0] max_val;
      max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return (val == max_val) ? val : val + 64'd1;
   endfunction

endpackage

// File: rtl/eth_status_counter.sv
// -----------------------------------------------------------------------------
// eth_status_counter
// One event channel: a saturating live counter, its snapshot shadow register
// and a sticky flag.
// Ports:
//   clock        : clock
//   reset        : asynchronous active-high reset
//   evt          : single-cycle event pulse (counts once per high cycle)
//   snap         : copy live counter into shadow this cycle
//   sticky_clear : clear the sticky flag (a same-cycle event wins)
//   shadow       : snapshot value of the live counter
//   sticky       : set on any event, held until cleared
// -----------------------------------------------------------------------------
module eth_status_counter
   import eth_status_monitor_pkg::*;
#(
   parameter int CNT_WIDTH     = 32,
   parameter bit CLEAR_ON_SNAP = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 evt,
   input  logic                 snap,
   input  logic                 sticky_clear,
   output logic [CNT_WIDTH-1:0] shadow,
   output logic                 sticky
);

   logic [CNT_WIDTH-1:0] live;
   logic [CNT_WIDTH-1:0] live_inc;

   assign live_inc = CNT_WIDTH'(sat_inc(64'(live), CNT_WIDTH));

   // NOTE: state is updated with non-blocking assignments so the shadow
   // captures the pre-edge live value even though live changes on the same edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         live   <= '0;
         shadow <= '0;
         sticky <= 1'b0;
      end else begin
         if (snap) begin
            shadow <= live;
            // Restarting from the current event rather than zero keeps an
            // event that coincides with the snapshot from being lost.
            if (CLEAR_ON_SNAP)
               live <= {{(CNT_WIDTH-1){1'b0}}, evt};
            else if (evt)
               live <= live_inc;
         end else if (evt) begin
            live <= live_inc;
         end
         sticky <= evt | (sticky & ~sticky_clear);
      end
   end

endmodule

// File: rtl/eth_status_monitor.sv
// -----------------------------------------------------------------------------
// eth_status_monitor
// Statistics block for the Ethernet MAC wrapper status pulses. Counts each
// event bit in a saturating counter, keeps per-event sticky flags, raises a
// masked interrupt and serves coherent snapshot reads over valid/ready.
// Ports:
//   clock, reset                 : clock125 domain, async active-high reset
//   event_in[NUM_EVENTS]         : single-cycle event pulses
//   snap_req                     : copy all live counters to shadows
//   rd_req_valid/ready/index     : read request (one outstanding at a time)
//   rd_resp_valid/ready/data/err : read response, held until accepted
//   sticky, sticky_clear         : sticky flags and their bitwise clear
//   irq_mask, irq                : interrupt enables and registered interrupt
// Optional feature: define ETH_STATUS_MONITOR_TIMESTAMP_EN to add a free-running
// cycle counter captured on snap_req and readable at index NUM_EVENTS.
// -----------------------------------------------------------------------------
module eth_status_monitor
   import eth_status_monitor_pkg::*;
#(
   parameter int NUM_EVENTS    = 16,
   parameter int CNT_WIDTH     = 32,
   parameter bit CLEAR_ON_SNAP = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_EVENTS-1:0] event_in,
   input  logic                  snap_req,
   input  logic                  rd_req_valid,
   output logic                  rd_req_ready,
   input  logic [RD_INDEX_W-1:0] rd_req_index,
   output logic                  rd_resp_valid,
   input  logic                  rd_resp_ready,
   output logic [CNT_WIDTH-1:0]  rd_resp_data,
   output logic                  rd_resp_err,
   output logic [NUM_EVENTS-1:0] sticky,
   input  logic [NUM_EVENTS-1:0] sticky_clear,
   input  logic [NUM_EVENTS-1:0] irq_mask,
   output logic                  irq
);

   logic [CNT_WIDTH-1:0] shadow [NUM_EVENTS];
   logic [CNT_WIDTH-1:0] sel_data;
   logic                 sel_err;
   rd_state_t            state;

   for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_chan
      eth_status_counter #(
         .CNT_WIDTH     (CNT_WIDTH),
         .CLEAR_ON_SNAP (CLEAR_ON_SNAP)
      ) u_cnt (
         .clock        (clock),
         .reset        (reset),
         .evt          (event_in[g]),
         .snap         (snap_req),
         .sticky_clear (sticky_clear[g]),
         .shadow       (shadow[g]),
         .sticky       (sticky[g])
      );
   end

`ifdef ETH_STATUS_MONITOR_TIMESTAMP_EN
   logic [CNT_WIDTH-1:0] ts_count;
   logic [CNT_WIDTH-1:0] ts_shadow;

   // Free-running and wrapping: it measures time between snapshots, not events.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ts_count  <= '0;
         ts_shadow <= '0;
      end else begin
         ts_count <= ts_count + CNT_WIDTH'(1);
         if (snap_req)
            ts_shadow <= ts_count;
      end
   end
`endif

   // NOTE: every output of this combinational block gets a default first so
   // unmatched indices cannot infer a latch.
   always_comb begin
      sel_data = '0;
      sel_err  = 1'b1;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         if (rd_req_index == RD_INDEX_W'(i)) begin
            sel_data = shadow[i];
            sel_err  = 1'b0;
         end
      end
`ifdef ETH_STATUS_MONITOR_TIMESTAMP_EN
      if (rd_req_index == RD_INDEX_W'(NUM_EVENTS)) begin
         sel_data = ts_shadow;
         sel_err  = 1'b0;
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         irq <= 1'b0;
      else
         irq <= |(sticky & irq_mask);
   end

   // Read FSM. The response is latched at request time, so a snapshot taken
   // while the response is held cannot alter it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         rd_req_ready  <= 1'b1;
         rd_resp_valid <= 1'b0;
         rd_resp_data  <= '0;
         rd_resp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rd_req_valid && rd_req_ready) begin
                  state         <= ST_RESP;
                  rd_req_ready  <= 1'b0;
                  rd_resp_valid <= 1'b1;
                  rd_resp_data  <= sel_data;
                  rd_resp_err   <= sel_err;
               end
            end
            ST_RESP: begin
               if (rd_resp_ready) begin
                  state         <= ST_IDLE;
                  rd_req_ready  <= 1'b1;
                  rd_resp_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_status_monitor.sv
// -----------------------------------------------------------------------------
// tb_eth_status_monitor
// Directed bench for eth_status_monitor (NUM_EVENTS=16, CNT_WIDTH=8,
// CLEAR_ON_SNAP=1). Read expectations go into a queue; a monitor process pops
// and compares on every accepted response. Honors
// ETH_STATUS_MONITOR_TIMESTAMP_EN for the timestamp read.
// -----------------------------------------------------------------------------
module tb_eth_status_monitor;

   localparam int NE = 16;
   localparam int CW = 8;

   typedef struct packed {
      logic [CW-1:0] data;
      logic          err;
   } exp_t;

   logic          clock;
   logic          reset;
   logic [NE-1:0] event_in;
   logic          snap_req;
   logic          rd_req_valid;
   logic          rd_req_ready;
   logic [6:0]    rd_req_index;
   logic          rd_resp_valid;
   logic          rd_resp_ready;
   logic [CW-1:0] rd_resp_data;
   logic          rd_resp_err;
   logic [NE-1:0] sticky;
   logic [NE-1:0] sticky_clear;
   logic [NE-1:0] irq_mask;
   logic          irq;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   eth_status_monitor #(
      .NUM_EVENTS    (NE),
      .CNT_WIDTH     (CW),
      .CLEAR_ON_SNAP (1'b1)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .event_in      (event_in),
      .snap_req      (snap_req),
      .rd_req_valid  (rd_req_valid),
      .rd_req_ready  (rd_req_ready),
      .rd_req_index  (rd_req_index),
      .rd_resp_valid (rd_resp_valid),
      .rd_resp_ready (rd_resp_ready),
      .rd_resp_data  (rd_resp_data),
      .rd_resp_err   (rd_resp_err),
      .sticky        (sticky),
      .sticky_clear  (sticky_clear),
      .irq_mask      (irq_mask),
      .irq           (irq)
   );

   initial begin
      clock = 1'b0;
      forever #4 clock = ~clock;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: samples just after the falling edge, when inputs
   // driven at the falling edge have settled and the next rising edge will
   // complete the handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #1;
         if (!reset && rd_resp_valid && rd_resp_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp: got data %0h err %0b with nothing pending",
                        rd_resp_data, rd_resp_err);
            end else begin
               e = exp_q.pop_front();
               check("resp_data", rd_resp_data, e.data);
               check("resp_err", rd_resp_err, e.err);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_snap();
      snap_req = 1'b1;
      step(1);
      snap_req = 1'b0;
   endtask

   // Issue one read; optionally hold rd_resp_ready low for 'hold' cycles,
   // checking the response stays put, with an optional snapshot in between.
   task automatic do_read(input logic [6:0] idx, input logic [CW-1:0] exp_data,
                          input logic exp_err, input int hold, input bit snap_mid);
      exp_t e;
      e.data = exp_data;
      e.err  = exp_err;
      exp_q.push_back(e);
      check("req_ready_idle", rd_req_ready, 1);
      if (hold > 0) rd_resp_ready = 1'b0;
      rd_req_valid = 1'b1;
      rd_req_index = idx;
      @(posedge clock);
      #1;
      check("resp_latency", rd_resp_valid, 1);
      @(negedge clock);
      rd_req_valid = 1'b0;
      for (int h = 0; h < hold; h++) begin
         #1;
         check("hold_req_ready", rd_req_ready, 0);
         check("hold_valid", rd_resp_valid, 1);
         check("hold_data", rd_resp_data, exp_data);
         check("hold_err", rd_resp_err, exp_err);
         snap_req = (h == 0) && snap_mid;
         @(negedge clock);
      end
      snap_req      = 1'b0;
      rd_resp_ready = 1'b1;
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
         @(negedge clock);
         #2;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL resp_timeout: %0d responses still pending", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      reset         = 1'b1;
      event_in      = '0;
      snap_req      = 1'b0;
      rd_req_valid  = 1'b0;
      rd_req_index  = '0;
      rd_resp_ready = 1'b1;
      sticky_clear  = '0;
      irq_mask      = '0;
      step(3);
      check("rst_req_ready", rd_req_ready, 1);
      check("rst_resp_valid", rd_resp_valid, 0);
      check("rst_resp_data", rd_resp_data, 0);
      check("rst_resp_err", rd_resp_err, 0);
      check("rst_sticky", sticky, 0);
      check("rst_irq", irq, 0);
      reset = 1'b0;
      step(2);

      // 1: five pulses on event 4
      event_in = 16'h0010;
      step(5);
      event_in = '0;
      pulse_snap();
      do_read(7'd4, 8'd5, 1'b0, 0, 1'b0);

      // 2: saturation at 255
      event_in = 16'h0001;
      step(300);
      event_in = '0;
      pulse_snap();
      do_read(7'd0, 8'd255, 1'b0, 0, 1'b0);

      // 3: event coincident with snapshot is kept in the restarted counter
      event_in = 16'h0004;
      step(7);
      snap_req = 1'b1;
      step(1);
      snap_req = 1'b0;
      event_in = '0;
      do_read(7'd2, 8'd7, 1'b0, 0, 1'b0);
      pulse_snap();
      do_read(7'd2, 8'd1, 1'b0, 0, 1'b0);
      do_read(7'd0, 8'd0, 1'b0, 0, 1'b0);

      // 4: out-of-range index with back-pressure; snapshot while held
      do_read(7'd20, 8'd0, 1'b1, 4, 1'b0);
      do_read(7'd2, 8'd1, 1'b0, 3, 1'b1);
`ifndef ETH_STATUS_MONITOR_TIMESTAMP_EN
      do_read(7'd16, 8'd0, 1'b1, 0, 1'b0);
`endif

      // 5: sticky set-wins, masked irq timing
      step(1);
      sticky_clear = '1;
      step(1);
      sticky_clear = '0;
      check("sticky_all_clear", sticky, 0);
      event_in     = 16'h0008;
      sticky_clear = 16'h0008;
      irq_mask     = 16'h0008;
      step(1);
      event_in     = '0;
      sticky_clear = '0;
      check("sticky_set_wins", sticky, 16'h0008);
      check("irq_lag", irq, 0);
      step(1);
      check("irq_set", irq, 1);
      sticky_clear = 16'h0008;
      step(1);
      sticky_clear = '0;
      check("sticky_cleared", sticky, 0);
      check("irq_still_high", irq, 1);
      step(1);
      check("irq_dropped", irq, 0);
      event_in = 16'h0020;
      step(1);
      event_in = '0;
      step(1);
      check("sticky_unmasked_bit", sticky, 16'h0020);
      check("irq_masked_off", irq, 0);

      // 6: reset during a held response
      event_in = 16'h0010;
      step(3);
      event_in      = '0;
      rd_resp_ready = 1'b0;
      rd_req_valid  = 1'b1;
      rd_req_index  = 7'd4;
      @(posedge clock);
      #1;
      check("pre_reset_valid", rd_resp_valid, 1);
      rd_req_valid = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      check("mid_reset_valid", rd_resp_valid, 0);
      check("mid_reset_ready", rd_req_ready, 1);
      check("mid_reset_data", rd_resp_data, 0);
      check("mid_reset_sticky", sticky, 0);
      check("mid_reset_irq", irq, 0);
      step(2);
      reset         = 1'b0;
      rd_resp_ready = 1'b1;
      irq_mask      = '0;
      step(100);
      pulse_snap();
      do_read(7'd4, 8'd0, 1'b0, 0, 1'b0);
      do_read(7'd0, 8'd0, 1'b0, 0, 1'b0);
`ifdef ETH_STATUS_MONITOR_TIMESTAMP_EN
      do_read(7'd16, 8'd100, 1'b0, 0, 1'b0);
`else
      do_read(7'd16, 8'd0, 1'b1, 0, 1'b0);
`endif

      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_status_monitor.md
Name: eth_status_monitor

Overview:
- Parametrised statistics block for the Ethernet MAC wrapper status outputs.
- Each status bit is a single-cycle event pulse: FIFO overflow, bad frame, good frame, bad FCS, and so on.
- Counts every bit in a saturating counter and keeps a sticky flag per bit. Raises a masked interrupt.
- Host software reads coherent snapshots through a valid/ready read port. Sits beside the MAC in the clock125 domain.

Parameters:
- NUM_EVENTS, 16, number of event inputs (1..64).
- CNT_WIDTH, 32, width of each counter and read data (8..64).
- CLEAR_ON_SNAP, 1, 1 = live counters restart on snapshot; 0 = live counters keep accumulating.

Ports:
- clock, input, 1, single clock for all logic.
- reset, input, 1, asynchronous active-high reset.
- event_in, input, NUM_EVENTS, one-cycle event pulses (level-high counts once per cycle).
- snap_req, input, 1, one-cycle pulse: copy all live counters to shadow registers.
- rd_req_valid, input, 1, read request valid.
- rd_req_ready, output, 1, read request ready.
- rd_req_index, input, 7, counter index to read.
- rd_resp_valid, output, 1, read response valid.
- rd_resp_ready, input, 1, read response ready.
- rd_resp_data, output, CNT_WIDTH, shadow value.
- rd_resp_err, output, 1, index out of range.
- sticky, output, NUM_EVENTS, per-event sticky flags.
- sticky_clear, input, NUM_EVENTS, one-cycle bitwise clear of sticky.
- irq_mask, input, NUM_EVENTS, interrupt enable per event.
- irq, output, 1, registered OR of (sticky & irq_mask).

Behaviour:
- Reset values: all counters, shadows, sticky, irq, rd_resp_valid, rd_resp_data and rd_resp_err are 0; rd_req_ready is 1. The read FSM goes to IDLE.
- Counting: event_in[i]=1 adds 1 to live[i]. At all-ones the counter holds (saturates) and never wraps.
- Snapshot: snap_req in cycle N gives shadow[i] = live[i] as of the start of cycle N.
  - CLEAR_ON_SNAP=1: live[i] becomes event_in[i] in cycle N, so no event is lost.
  - CLEAR_ON_SNAP=0: live[i] keeps counting normally.
- Sticky: sticky[i] sets on event_in[i]. sticky_clear[i] clears it. If set and clear occur in the same cycle, set wins.
- irq: one cycle behind sticky/irq_mask changes.
- Read FSM, IDLE -> RESP:
  - In IDLE, rd_req_ready=1. A transfer (valid && ready) moves to RESP on the next edge.
  - On that edge rd_resp_valid=1 and rd_resp_data=shadow[index], registered.
  - In RESP, rd_req_ready=0. rd_resp_* stay stable until rd_resp_ready=1, then the FSM returns to IDLE.
  - Latency: request transfer in cycle N gives response valid in cycle N+1. There is at most one outstanding request.
  - Index >= NUM_EVENTS (and not the timestamp index): rd_resp_data=0, rd_resp_err=1.
  - A snapshot during RESP does not change the held response.
- Reset mid-operation: asynchronous return to reset values. A pending response is discarded.

Optional Feature:
- Macro: ETH_STATUS_MONITOR_TIMESTAMP_EN.
- Defined:
  - A free-running CNT_WIDTH cycle counter (wraps) is captured into a timestamp shadow on snap_req.
  - The shadow is readable at index NUM_EVENTS with rd_resp_err=0.
- Undefined:
  - No timestamp logic.
  - Index NUM_EVENTS returns error like any other out-of-range index.

Decomposition:
- Package eth_status_monitor_pkg holds:
  - read FSM state enum (ST_IDLE, ST_RESP);
  - index width constant RD_INDEX_W=7;
  - a saturating-increment function.
- Sub-module eth_status_counter is instantiated NUM_EVENTS times. Each instance holds:
  - one live counter, one shadow register and one sticky flag;
  - inputs event, snap, sticky_clear.

Test Plan:
1. Reset release, 5 pulses on event_in[4], snap_req, read index 4 -> rd_resp_data=5, rd_resp_err=0, response one cycle after the request transfer.
2. CNT_WIDTH=8, event_in[0] held high 300 cycles, snap, read 0 -> 255 (saturated, no wrap).
3. event_in[2] high in the same cycle as snap_req, CLEAR_ON_SNAP=1, live=7 -> shadow=7. Next snap with no events reads 1.
4. Read index 20 with NUM_EVENTS=16 -> data 0, err 1. Hold rd_resp_ready low 4 cycles -> rd_req_ready stays 0 and the response stays stable.
5. Simultaneous event_in[3] and sticky_clear[3] -> sticky[3] stays 1. irq_mask[3]=1 -> irq=1 one cycle later. sticky_clear alone -> irq drops one cycle after sticky clears.
6. Assert reset during RESP -> rd_resp_valid=0 and all counters 0 immediately. With the TIMESTAMP_EN macro, snap at cycle 100 after reset, read index 16 -> 100.
